dff_data_capture: RTL and testbench
===================================

Name: dff_data_capture

Overview:
- Serial receiver for the DFF error-count stream: deserializes the single-bit data line back into 20 x 16-bit error counts (chip 0 chains 0-9, then chip 1 chains 0-9).
- Bits arrive LSB first on data_clk.
- Used on the test-harness side and in FPGA loopback, so the host can read complete frames through a double-buffered register bank.
- Detects when the host fails to consume a frame (overrun).

Parameters:
- WORD_W, 16, bits per error-count word.
- NUM_WORDS, 20, words per frame (10 per chip).
- SKIP_BITS, 1, bits discarded after capture is enabled, to align with the transmitter's registered output; range 0-7.

Ports:
- data_clk, in, 1, capture clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- rx_en, in, 1, capture enable; low aborts any partial frame.
- data_in, in, 1, serial data, sampled on each rising data_clk edge.
- frame_ack, in, 1, host acknowledge of the current frame; 1-cycle pulse.
- rd_idx, in, 5, word index for readback (0-19).
- rd_data, out, 16, word rbuf[rd_idx]; combinational; 0 when rd_idx >= NUM_WORDS.
- frame_valid, out, 1, a completed, unacknowledged frame is in rbuf.
- frame_done, out, 1, 1-cycle pulse after each completed frame.
- frame_count, out, 16, completed frames since reset; wraps 0xFFFF to 0.
- overrun, out, 1, sticky: a frame completed while the previous one was still unacknowledged.
- busy, out, 1, state is not IDLE.

Behaviour:
Reset values:
- All outputs are 0 after reset: frame_valid, frame_done, frame_count, overrun, busy.
- Internal state after reset: rbuf, wbuf and the shift register are 0; state is IDLE; skip_cnt, bit_cnt and word_cnt are 0.
- Reset overrides every other input.

States:
- IDLE, SKIP, RECV.

Bit consumption:
- A bit is consumed on every edge where reset=0 and rx_en=1, including the first edge on which rx_en is seen high in IDLE.

Transitions:
- IDLE, rx_en=1:
  - If SKIP_BITS > 0: the consumed bit is discarded, skip_cnt becomes 1, and the state goes to SKIP. If SKIP_BITS = 1, the state goes directly to RECV instead.
  - If SKIP_BITS = 0: the bit is captured as bit 0 of word 0, and the state goes to RECV.
- SKIP: discard the bit and increment skip_cnt; move to RECV when skip_cnt reaches SKIP_BITS.
- RECV: shift register sr <= {data_in, sr[15:1]}; bit_cnt increments.
  - At bit_cnt = 15: wbuf[word_cnt] <= {data_in, sr[15:1]}; bit_cnt returns to 0; word_cnt increments.
- Frame completion (word_cnt = 19 and bit_cnt = 15 in RECV):
  - All 20 words, including the word being completed, are copied to rbuf on the same edge.
  - word_cnt returns to 0.
  - The state stays in RECV; the next frame starts on the following edge with no re-skip.
- rx_en=0 in any state: go to IDLE, clear all counters, and discard the partial wbuf contents. rbuf, frame_valid and frame_count are untouched. The next rx_en rise re-applies SKIP.

Registered on the completion edge (visible the following cycle):
- frame_done = 1 for exactly one cycle.
- frame_count increments.
- frame_valid = 1.
- If frame_valid was 1 and frame_ack=0 on that edge, overrun is set to 1. It clears only on reset.

Acknowledge:
- frame_ack=1 with no completion on that edge: frame_valid is cleared.
- frame_ack=1 on the same edge as a completion: frame_valid stays 1 and overrun is not set.

Readback:
- rbuf changes only on completion edges. A read in any other cycle therefore returns a coherent frame.

Latency:
- From the first rx_en=1 edge, the frame completes on edge SKIP_BITS + 320.
- frame_done is high during the cycle after that edge.

Test Plan:
- Basic frame, SKIP_BITS=1: reset, then rx_en=1. Drive 1 junk bit, then words w[k] = 0x1111*k (k=0-15), 0xA5C3, 0xFFFF, 0x0001, 0x8000, all LSB first -> frame_done pulses after edge 321; frame_count=1; rd_idx=16 returns 0xA5C3; rd_idx=19 returns 0x8000; rd_idx=25 returns 0.
- Continuous stream: send 3 back-to-back frames with distinct data, acking after each frame_done -> frame_count=3; rbuf holds frame 3; overrun=0; no skip applied between frames.
- Overrun: send 2 frames without frame_ack -> overrun=1 after the second completion; rbuf holds frame 2. frame_ack then clears frame_valid, but overrun stays 1 until reset.
- Ack on the completion edge: assert frame_ack on the edge frame 2 completes, with frame_valid=1 -> frame_valid stays 1 and overrun stays 0.
- Abort: drop rx_en at bit 100 of frame 2 -> state goes IDLE and busy=0; rbuf and frame_count still reflect frame 1. Re-enable -> 1 bit skipped, then a full new frame is captured correctly.
- Reset mid-frame: assert reset at bit 200 -> all outputs 0 on the next cycle; rd_data=0 for every index.

Source files
------------

// File: rtl/dff_data_capture.sv
// Serial receiver for the DFF error-count stream: rebuilds NUM_WORDS x WORD_W counts
// (LSB first) and presents whole frames to the host through a double-buffered bank.
module dff_data_capture #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 20,
   parameter int SKIP_BITS = 1
) (
   input  logic              data_clk,
   input  logic              reset,
   input  logic              rx_en,
   input  logic              data_in,
   input  logic              frame_ack,
   input  logic [4:0]        rd_idx,
   output logic [WORD_W-1:0] rd_data,
   output logic              frame_valid,
   output logic              frame_done,
   output logic [15:0]       frame_count,
   output logic              overrun,
   output logic              busy,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, RECV = 2'd2} state_t;

   localparam int              BCW       = $clog2(WORD_W);
   localparam logic [BCW-1:0]  LAST_BIT  = BCW'(WORD_W - 1);
   localparam logic [4:0]      LAST_WORD = 5'(NUM_WORDS - 1);
   localparam logic [2:0]      SKIP_N    = 3'(SKIP_BITS);

   state_t             state, state_nxt;
   logic [2:0]         skip_cnt;
   logic [BCW-1:0]     bit_cnt;
   logic [4:0]         word_cnt;
   logic [WORD_W-1:0]  sr;
   logic [WORD_W-1:0]  sr_nxt;
   logic [WORD_W-1:0]  wbuf [NUM_WORDS];
   logic [WORD_W-1:0]  rbuf [NUM_WORDS];
   logic               shift_en, word_end, frame_end;

   always_ff @(posedge data_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // With no skip, the very first enabled bit is already data bit 0 of word 0.
   always_comb begin
      state_nxt = state;
      shift_en  = rx_en && (state == RECV || (state == IDLE && SKIP_BITS == 0));
      word_end  = shift_en && (bit_cnt == LAST_BIT);
      frame_end = word_end && (word_cnt == LAST_WORD);
      sr_nxt    = {data_in, sr[WORD_W-1:1]};
      case (state)
         IDLE: if (rx_en) state_nxt = (SKIP_BITS <= 1) ? RECV : SKIP;
         SKIP: if (skip_cnt + 3'd1 == SKIP_N) state_nxt = RECV;
         RECV: state_nxt = RECV;
         default: state_nxt = IDLE;
      endcase
      if (!rx_en) state_nxt = IDLE;
   end

   always_ff @(posedge data_clk) begin
      if (reset) begin
         skip_cnt <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         sr       <= '0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            wbuf[i] <= '0;
            rbuf[i] <= '0;
         end
      end else if (!rx_en) begin
         skip_cnt <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         sr       <= '0;
         for (int i = 0; i < NUM_WORDS; i++) wbuf[i] <= '0;
      end else begin
         if (state == IDLE && SKIP_BITS > 0) skip_cnt <= 3'd1;
         else if (state == SKIP)             skip_cnt <= skip_cnt + 3'd1;
         if (shift_en) begin
            sr      <= sr_nxt;
            bit_cnt <= word_end ? '0 : bit_cnt + BCW'(1);
         end
         if (word_end) begin
            wbuf[word_cnt] <= sr_nxt;
            word_cnt       <= frame_end ? 5'd0 : word_cnt + 5'd1;
         end
         // The word finishing on this edge goes straight to rbuf alongside the rest.
         if (frame_end) begin
            for (int i = 0; i < NUM_WORDS; i++)
               rbuf[i] <= (i == NUM_WORDS - 1) ? sr_nxt : wbuf[i];
         end
      end
   end

   // Host handshake: frame_valid rises on completion and falls on frame_ack;
   // an ack coinciding with a completion consumes the old frame, so no overrun.
   always_ff @(posedge data_clk) begin
      if (reset) begin
         frame_valid <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            frame_valid <= 1'b1;
            frame_count <= frame_count + 16'd1;
            if (frame_valid && !frame_ack) overrun <= 1'b1;
         end else if (frame_ack) begin
            frame_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < NUM_WORDS) rd_data = rbuf[rd_idx];
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_dff_data_capture.sv
// Directed bench for dff_data_capture: readback vector table plus multi-frame,
// overrun, acknowledge, abort and mid-frame reset sequences.
module tb_dff_data_capture;

   logic        data_clk = 1'b0;
   logic        reset    = 1'b1;
   logic        rx_en    = 1'b0;
   logic        data_in  = 1'b0;
   logic        frame_ack = 1'b0;
   logic [4:0]  rd_idx   = 5'd0;
   logic [15:0] rd_data;
   logic        frame_valid, frame_done, overrun, busy;
   logic [15:0] frame_count;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] frm [20];
   logic [15:0] exp_q [$];

   typedef struct {
      logic [4:0]  idx;
      logic [15:0] exp;
   } rd_vec_t;
   rd_vec_t vecs [11];

   dff_data_capture dut (
      .data_clk    (data_clk),
      .reset       (reset),
      .rx_en       (rx_en),
      .data_in     (data_in),
      .frame_ack   (frame_ack),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .frame_valid (frame_valid),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .overrun     (overrun),
      .busy        (busy),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   always #50 data_clk = ~data_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks: one call = one rising edge, outputs sampled 1 time unit later
   task automatic tick(input logic en, input logic d, input logic ack);
      rx_en     = en;
      data_in   = d;
      frame_ack = ack;
      @(posedge data_clk);
      #1;
      frame_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic send_bits(input int n, input logic ack_first);
      for (int i = 0; i < n; i++)
         tick(1'b1, frm[i / 16][i % 16], ack_first && (i == 0));
   endtask

   task automatic send_frame(input string name, input logic ack_first, input logic ack_last);
      exp_q.delete();
      for (int k = 0; k < 20; k++) exp_q.push_back(frm[k]);
      for (int i = 0; i < 320; i++) begin
         tick(1'b1, frm[i / 16][i % 16], (ack_first && i == 0) || (ack_last && i == 319));
         if (i == 318) check({name, "_done_early"}, 32'(frame_done), 32'd0);
      end
      check({name, "_done"}, 32'(frame_done), 32'd1);
      check({name, "_valid"}, 32'(frame_valid), 32'd1);
   endtask

   // scoreboard: rbuf must equal the expected frame held in exp_q
   task automatic check_rbuf(input string name);
      check({name, "_qsize"}, 32'(exp_q.size()), 32'd20);
      for (int i = 0; i < 20 && i < exp_q.size(); i++) begin
         rd_idx = 5'(i);
         #1;
         check($sformatf("%s_rd%0d", name, i), 32'(rd_data), 32'(exp_q[i]));
      end
   endtask

   task automatic fill_seed(input int s);
      for (int k = 0; k < 20; k++)
         frm[k] = 16'((s * 32'h9E37) ^ (k * 32'h0101) ^ (k << 12) ^ s);
   endtask

   initial begin
      // basic frame: 0x1111*k then the four boundary words
      for (int k = 0; k < 16; k++) frm[k] = 16'(32'h1111 * k);
      frm[16] = 16'hA5C3; frm[17] = 16'hFFFF; frm[18] = 16'h0001; frm[19] = 16'h8000;
      vecs[0]  = '{5'd0,  16'h0000};
      vecs[1]  = '{5'd1,  16'h1111};
      vecs[2]  = '{5'd5,  16'h5555};
      vecs[3]  = '{5'd15, 16'hFFFF};
      vecs[4]  = '{5'd16, 16'hA5C3};
      vecs[5]  = '{5'd17, 16'hFFFF};
      vecs[6]  = '{5'd18, 16'h0001};
      vecs[7]  = '{5'd19, 16'h8000};
      vecs[8]  = '{5'd20, 16'h0000};
      vecs[9]  = '{5'd25, 16'h0000};
      vecs[10] = '{5'd31, 16'h0000};

      do_reset();
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_done",  32'(frame_done),  32'd0);
      check("rst_count", 32'(frame_count), 32'd0);
      check("rst_ovr",   32'(overrun),     32'd0);
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_state", 32'(fsm_state),   32'd0);

      tick(1'b1, 1'b1, 1'b0);                // junk bit, discarded
      check("skip_busy", 32'(busy), 32'd1);
      send_frame("basic", 1'b0, 1'b0);
      check("basic_count", 32'(frame_count), 32'd1);
      for (int v = 0; v < 11; v++) begin
         rd_idx = vecs[v].idx;
         #1;
         check($sformatf("basic_vec_idx%0d", vecs[v].idx), 32'(rd_data), 32'(vecs[v].exp));
      end
      tick(1'b0, 1'b0, 1'b0);
      check("basic_done_pulse", 32'(frame_done), 32'd0);
      check("basic_valid_hold", 32'(frame_valid), 32'd1);

      // continuous stream, acking on the first bit of each following frame
      do_reset();
      tick(1'b1, 1'b0, 1'b0);
      fill_seed(1); send_frame("cont1", 1'b0, 1'b0);
      fill_seed(2); send_frame("cont2", 1'b1, 1'b0);
      fill_seed(3); send_frame("cont3", 1'b1, 1'b0);
      check("cont_count", 32'(frame_count), 32'd3);
      check("cont_ovr",   32'(overrun),     32'd0);
      check_rbuf("cont_rbuf");

      // ack on the completion edge while the previous frame is still valid
      do_reset();
      tick(1'b1, 1'b1, 1'b0);
      fill_seed(4); send_frame("ackc1", 1'b0, 1'b0);
      fill_seed(5); send_frame("ackc2", 1'b0, 1'b1);
      check("ackc_ovr",   32'(overrun),     32'd0);
      check("ackc_count", 32'(frame_count), 32'd2);
      check_rbuf("ackc_rbuf");

      // abort at bit 100 of frame 2, then re-enable with a fresh skip
      do_reset();
      tick(1'b1, 1'b0, 1'b0);
      fill_seed(6); send_frame("abt1", 1'b0, 1'b0);
      fill_seed(7); send_bits(100, 1'b0);
      check("abt_busy_recv", 32'(fsm_state), 32'd2);
      tick(1'b0, 1'b1, 1'b0);
      check("abt_busy",  32'(busy),        32'd0);
      check("abt_state", 32'(fsm_state),   32'd0);
      check("abt_count", 32'(frame_count), 32'd1);
      check("abt_valid", 32'(frame_valid), 32'd1);
      fill_seed(6);
      check_rbuf("abt_rbuf_old");
      tick(1'b1, 1'b1, 1'b0);
      fill_seed(8); send_frame("abt2", 1'b0, 1'b0);
      check("abt2_count", 32'(frame_count), 32'd2);
      check_rbuf("abt2_rbuf");

      // overrun: two frames with no ack
      do_reset();
      tick(1'b1, 1'b0, 1'b0);
      fill_seed(9);  send_frame("ovr1", 1'b0, 1'b0);
      check("ovr1_flag", 32'(overrun), 32'd0);
      fill_seed(10); send_frame("ovr2", 1'b0, 1'b0);
      check("ovr2_flag", 32'(overrun), 32'd1);
      check_rbuf("ovr2_rbuf");
      tick(1'b1, frm[0][0], 1'b1);
      check("ovr_ack_valid", 32'(frame_valid), 32'd0);
      check("ovr_sticky",    32'(overrun),     32'd1);

      // reset 200 bits into the next frame
      for (int i = 1; i < 200; i++) tick(1'b1, frm[i / 16][i % 16], 1'b0);
      reset = 1'b1;
      tick(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      check("mrst_valid", 32'(frame_valid), 32'd0);
      check("mrst_done",  32'(frame_done),  32'd0);
      check("mrst_count", 32'(frame_count), 32'd0);
      check("mrst_ovr",   32'(overrun),     32'd0);
      check("mrst_busy",  32'(busy),        32'd0);
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         check($sformatf("mrst_rd%0d", i), 32'(rd_data), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
